// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver and frame decoder for the AD9481 capture path.
// Define UART_CMD_CSUM_EN for the 6-byte frame with trailing XOR checksum; undefined gives the 5-byte frame.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned LEN_MAX      = 8191,
    parameter int unsigned TIMEOUT_BITS = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        cap_start,
    output logic [12:0] cap_len,
    output logic        adc_pdwn_req,
    output logic        frame_err,
    output logic        rx_busy
);
    localparam int unsigned DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned HALF   = DIV / 2;
    localparam int unsigned CNT_W  = $clog2(DIV);
    localparam int unsigned TO_CYC = TIMEOUT_BITS * DIV;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
    localparam int unsigned LEN_W  = 13;
`ifdef UART_CMD_CSUM_EN
    localparam int unsigned LH_W   = 8;
`else
    localparam int unsigned LH_W   = 5;
`endif
    localparam logic [LEN_W-1:0] LEN_CAP = (LEN_MAX > 32'd8191) ? 13'h1FFF : LEN_W'(LEN_MAX);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
`ifdef UART_CMD_CSUM_EN
    typedef enum logic [2:0] {P_HDR0, P_HDR1, P_CMD, P_LEN_H, P_LEN_L, P_CSUM, P_EXEC} parse_state_e;
`else
    typedef enum logic [2:0] {P_HDR0, P_HDR1, P_CMD, P_LEN_H, P_LEN_L, P_EXEC} parse_state_e;
`endif

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    bit_state_e       b_state_q, b_state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             stop_err_q, stop_err_d;

    // Bit engine: half-bit wait to the start-bit centre, then one sample per DIV cycles
    always_comb begin
        b_state_d    = b_state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (b_state_q)
            B_IDLE: begin
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) b_state_d = B_START;
            end
            B_START: begin
                if (bit_cnt_q == CNT_W'(HALF - 1)) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    b_state_d = rx_sync_q ? B_IDLE : B_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (bit_cnt_q == CNT_W'(DIV - 1)) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) b_state_d = B_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            B_STOP: begin
                if (bit_cnt_q == CNT_W'(DIV - 1)) begin
                    bit_cnt_d    = '0;
                    byte_valid_d = rx_sync_q;
                    stop_err_d   = !rx_sync_q;
                    b_state_d    = B_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: b_state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state_q    <= B_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            b_state_q    <= b_state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    parse_state_e     p_state_q, p_state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [LH_W-1:0]  len_h_q, len_h_d;
    logic [7:0]       len_l_q, len_l_d;
    logic             cap_start_q, cap_start_d;
    logic [LEN_W-1:0] cap_len_q, cap_len_d;
    logic             pdwn_q, pdwn_d;
    logic             frame_err_q, frame_err_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] frame_len;

    assign frame_len = {len_h_q[4:0], len_l_q};

    // Frame parser; EXEC is the single cycle after the final byte
    always_comb begin
        p_state_d   = p_state_q;
        to_cnt_d    = to_cnt_q;
        cmd_d       = cmd_q;
        len_h_d     = len_h_q;
        len_l_d     = len_l_q;
        cap_start_d = 1'b0;
        cap_len_d   = cap_len_q;
        pdwn_d      = pdwn_q;
        frame_err_d = 1'b0;
        if (p_state_q == P_EXEC) begin
            p_state_d = P_HDR0;
            case (cmd_q)
                8'h01: begin
                    if (frame_len == '0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        cap_start_d = 1'b1;
                        cap_len_d   = (frame_len > LEN_CAP) ? LEN_CAP : frame_len;
                    end
                end
                8'h02:   pdwn_d = len_l_q[0];
                default: frame_err_d = 1'b1;
            endcase
        end else if (stop_err_q) begin
            p_state_d   = P_HDR0;
            frame_err_d = 1'b1;
        end else if (byte_valid_q) begin
            case (p_state_q)
                P_HDR0: if (shift_q == 8'h55) p_state_d = P_HDR1;
                P_HDR1: begin
                    if (shift_q == 8'hAA)      p_state_d = P_CMD;
                    else if (shift_q != 8'h55) p_state_d = P_HDR0;
                end
                P_CMD: begin
                    cmd_d     = shift_q;
                    p_state_d = P_LEN_H;
                end
                P_LEN_H: begin
                    len_h_d   = shift_q[LH_W-1:0];
                    p_state_d = P_LEN_L;
                end
`ifdef UART_CMD_CSUM_EN
                P_LEN_L: begin
                    len_l_d   = shift_q;
                    p_state_d = P_CSUM;
                end
                P_CSUM: begin
                    if (shift_q == (cmd_q ^ len_h_q ^ len_l_q)) begin
                        p_state_d = P_EXEC;
                    end else begin
                        p_state_d   = P_HDR0;
                        frame_err_d = 1'b1;
                    end
                end
`else
                P_LEN_L: begin
                    len_l_d   = shift_q;
                    p_state_d = P_EXEC;
                end
`endif
                default: p_state_d = P_HDR0;
            endcase
        end else if (p_state_q != P_HDR0) begin
            if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
                p_state_d   = P_HDR0;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
        // A completed byte or a return to HDR0 restarts the inter-byte timeout
        if (byte_valid_q || p_state_d == P_HDR0) to_cnt_d = '0;
        busy_d = (p_state_d != P_HDR0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= P_HDR0;
            to_cnt_q    <= '0;
            cmd_q       <= '0;
            len_h_q     <= '0;
            len_l_q     <= '0;
            cap_start_q <= 1'b0;
            cap_len_q   <= '0;
            pdwn_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            to_cnt_q    <= to_cnt_d;
            cmd_q       <= cmd_d;
            len_h_q     <= len_h_d;
            len_l_q     <= len_l_d;
            cap_start_q <= cap_start_d;
            cap_len_q   <= cap_len_d;
            pdwn_q      <= pdwn_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cap_start    = cap_start_q;
    assign cap_len      = cap_len_q;
    assign adc_pdwn_req = pdwn_q;
    assign frame_err    = frame_err_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Testbench for uart_cmd_rx: table-driven frames, hand-written corner sequences and random frames vs a frame-level model.
// Follows UART_CMD_CSUM_EN to choose 6-byte or 5-byte frames.
module tb_uart_cmd_rx;
    localparam int unsigned CLK_FREQ     = 1_600_000;
    localparam int unsigned BAUD         = 100_000;
    localparam int unsigned LEN_MAX      = 6000;
    localparam int unsigned TIMEOUT_BITS = 100;
    localparam int unsigned DIV          = (CLK_FREQ + BAUD / 2) / BAUD;
`ifdef UART_CMD_CSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        cap_start;
    logic [12:0] cap_len;
    logic        adc_pdwn_req;
    logic        frame_err;
    logic        rx_busy;

    uart_cmd_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .LEN_MAX     (LEN_MAX),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .cap_start   (cap_start),
        .cap_len     (cap_len),
        .adc_pdwn_req(adc_pdwn_req),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp, n_bad;
    int n_start, n_err, n_both;
    logic [12:0] m_len;
    logic        m_pdwn;

    // Pulse observer, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (cap_start) n_start++;
            if (frame_err) n_err++;
            if (cap_start && frame_err) n_both++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(bad_stop ? 1'b0 : 1'b1);
        if (bad_stop) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] s, input bit pre, input int bad);
        logic [7:0] q[$];
        q.push_back(8'h55);
        if (pre) q.push_back(8'h55);
        q.push_back(8'hAA);
        q.push_back(c);
        q.push_back(h);
        q.push_back(l);
`ifdef UART_CMD_CSUM_EN
        q.push_back(s);
`else
        if (s == 8'h00) q.push_back(8'h00);
        void'(q.pop_back());
        if (s != 8'h00) q.push_back(l);
        void'(q.pop_back());
        q.push_back(l);
`endif
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], i == bad);
            if (i == bad) break;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] c, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] s, input bit pre, input int bad,
                             input int es, input int ee, input logic [12:0] el, input logic ep);
        int s0, e0;
        s0 = n_start;
        e0 = n_err;
        send_frame(c, h, l, s, pre, bad);
        repeat (2 * DIV) @(posedge clk);
        #1;
        check({tag, " cap_start pulses"}, n_start - s0, es);
        check({tag, " frame_err pulses"}, n_err - e0, ee);
        check({tag, " cap_len"}, int'(cap_len), int'(el));
        check({tag, " adc_pdwn_req"}, int'(adc_pdwn_req), int'(ep));
        check({tag, " rx_busy"}, int'(rx_busy), 0);
    endtask

    // Frame-level reference: outcome of one complete frame from the decode rules
    task automatic model(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                         input logic [7:0] s, input int bad, output int es, output int ee);
        int len;
        es  = 0;
        ee  = 0;
        len = int'(h[4:0]) * 256 + int'(l);
        if (bad >= 0) ee = 1;
`ifdef UART_CMD_CSUM_EN
        else if (s != (c ^ h ^ l)) ee = 1;
`endif
        else if (c == 8'h01) begin
            if (len == 0) ee = 1;
            else begin
                es    = 1;
                m_len = 13'((len > int'(LEN_MAX)) ? int'(LEN_MAX) : len);
            end
        end else if (c == 8'h02) m_pdwn = l[0];
        else ee = 1;
    endtask

    typedef struct {
        logic [7:0]  cmd, lh, ll, cs;
        bit          pre55;
        int          exp_start, exp_err;
        logic [12:0] exp_len;
        logic        exp_pdwn;
    } vec_t;

    vec_t vec [11];

    initial begin
        int s0, e0;
        vec[0]  = '{8'h01, 8'h10, 8'h00, 8'h11, 1'b0, 1, 0, 13'h1000, 1'b0};
        vec[1]  = '{8'h01, 8'hFF, 8'hFF, 8'h01, 1'b0, 1, 0, 13'd6000, 1'b0};
        vec[2]  = '{8'h02, 8'h00, 8'h01, 8'h03, 1'b0, 0, 0, 13'd6000, 1'b1};
`ifdef UART_CMD_CSUM_EN
        vec[3]  = '{8'h01, 8'h10, 8'h00, 8'h12, 1'b0, 0, 1, 13'd6000, 1'b1};
`else
        vec[3]  = '{8'h01, 8'h10, 8'h00, 8'h12, 1'b0, 1, 0, 13'h1000, 1'b1};
`endif
        vec[4]  = '{8'h01, 8'h00, 8'h20, 8'h21, 1'b1, 1, 0, 13'h0020, 1'b1};
        vec[5]  = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 0, 1, 13'h0020, 1'b1};
        vec[6]  = '{8'h07, 8'h00, 8'h05, 8'h02, 1'b0, 0, 1, 13'h0020, 1'b1};
        vec[7]  = '{8'h02, 8'hE0, 8'h00, 8'hE2, 1'b0, 0, 0, 13'h0020, 1'b0};
        vec[8]  = '{8'h01, 8'hE0, 8'h05, 8'hE4, 1'b0, 1, 0, 13'd5,    1'b0};
        vec[9]  = '{8'h01, 8'h17, 8'h71, 8'h67, 1'b0, 1, 0, 13'd6000, 1'b0};
        vec[10] = '{8'h01, 8'h17, 8'h70, 8'h66, 1'b0, 1, 0, 13'd6000, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset cap_start", int'(cap_start), 0);
        check("reset cap_len", int'(cap_len), 0);
        check("reset adc_pdwn_req", int'(adc_pdwn_req), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset rx_busy", int'(rx_busy), 0);
        rst_n = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            run_frame($sformatf("vec%0d", i), vec[i].cmd, vec[i].lh, vec[i].ll, vec[i].cs,
                      vec[i].pre55, -1, vec[i].exp_start, vec[i].exp_err, vec[i].exp_len, vec[i].exp_pdwn);

        // Low stop bit on the CMD byte
        run_frame("stop_err", 8'h01, 8'h10, 8'h00, 8'h11, 1'b0, 2, 0, 1, 13'd6000, 1'b0);

        // Inter-byte timeout after the header
        s0 = n_start;
        e0 = n_err;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("timeout busy in frame", int'(rx_busy), 1);
        repeat (99) drive_bit(1'b1);
        check("timeout not early", n_err - e0, 0);
        repeat (2) drive_bit(1'b1);
        check("timeout frame_err", n_err - e0, 1);
        check("timeout no cap_start", n_start - s0, 0);
        check("timeout rx_busy", int'(rx_busy), 0);
        run_frame("after_timeout", 8'h01, 8'h00, 8'h30, 8'h31, 1'b0, -1, 1, 0, 13'h0030, 1'b0);
        run_frame("pdwn_on", 8'h02, 8'h00, 8'h01, 8'h03, 1'b0, -1, 0, 0, 13'h0030, 1'b1);

        // Reset in the middle of the LEN_L byte
        s0 = n_start;
        e0 = n_err;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst cap_len", int'(cap_len), 0);
        check("midrst adc_pdwn_req", int'(adc_pdwn_req), 0);
        check("midrst rx_busy", int'(rx_busy), 0);
        check("midrst cap_start", int'(cap_start), 0);
        check("midrst frame_err", int'(frame_err), 0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("midrst no pulses", (n_start - s0) + (n_err - e0), 0);
        run_frame("after_rst", 8'h01, 8'h00, 8'h07, 8'h06, 1'b0, -1, 1, 0, 13'd7, 1'b0);

        m_len  = 13'd7;
        m_pdwn = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] c, h, l, s;
            int r, bad, es, ee;
            r = int'($urandom_range(0, 9));
            c = (r < 4) ? 8'h01 : (r < 7) ? 8'h02 : 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                h = h & 8'hE0;
                l = 8'h00;
            end
            s = c ^ h ^ l;
            if ($urandom_range(0, 4) == 0) s = s ^ 8'(32'd1 << $urandom_range(0, 7));
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            model(c, h, l, s, bad, es, ee);
            run_frame($sformatf("rand%0d", k), c, h, l, s, 1'b0, bad, es, ee, m_len, m_pdwn);
        end

        check("cap_start with frame_err same cycle", n_both, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
